// File: rtl/cpu_types_pkg.sv
// Shared pipeline types for the forwarding and hazard logic.
// Holds the result kinds, the forwarding origins and the load-use FSM states.
package cpu_types_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {RK_ALU, RK_LUI, RK_LINK, RK_LOAD} res_kind_t;
  typedef enum logic [1:0] {FO_NONE, FO_EX, FO_WB, FO_HIST} fwd_origin_t;
  typedef enum logic {LU_RUN, LU_LDWAIT} lu_state_t;

  // A producer only matters when it writes a register other than r0.
  function automatic logic is_live(input logic wen, input logic [REG_W-1:0] dest);
    return wen && (dest != '0);
  endfunction

endpackage

// File: rtl/fwd_result_mux.sv
// Turns a producer's result kind and raw sources into the value it writes back.
module fwd_result_mux
  import cpu_types_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        kind,
  input  logic [DATA_W-1:0] alu,
  input  logic [15:0]       imm,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = alu;
    case (res_kind_t'(kind))
      RK_ALU:  result = alu;
      RK_LUI:  result = DATA_W'({imm, 16'h0000});
      RK_LINK: result = pc + DATA_W'(4);
      RK_LOAD: result = load_data;
      default: result = alu;
    endcase
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding from EX/MEM, MEM/WB and a retired-writeback history,
// plus the load-use stall FSM and a saturating stall counter.
module fwd_hazard_unit
  import cpu_types_pkg::*;
#(
  parameter int NUM_SRC     = 2,
  parameter int HIST        = 2,
  parameter int DATA_W      = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NUM_SRC*REG_W-1:0]    src_sel,
  input  logic [NUM_SRC-1:0]          src_used,
  input  logic                        ex_wen,
  input  logic [REG_W-1:0]            ex_dest,
  input  logic [1:0]                  ex_kind,
  input  logic [DATA_W-1:0]           ex_alu,
  input  logic [15:0]                 ex_imm,
  input  logic [DATA_W-1:0]           ex_pc,
  input  logic [DATA_W-1:0]           ex_load_data,
  input  logic                        mem_ready,
  input  logic                        wb_wen,
  input  logic [REG_W-1:0]            wb_dest,
  input  logic [1:0]                  wb_kind,
  input  logic [DATA_W-1:0]           wb_alu,
  input  logic [15:0]                 wb_imm,
  input  logic [DATA_W-1:0]           wb_pc,
  input  logic [DATA_W-1:0]           wb_load_data,
  input  logic                        adv,
  input  logic                        flush,
  output logic [NUM_SRC-1:0]          fwd_valid,
  output logic [NUM_SRC*DATA_W-1:0]   fwd_data,
  output logic [NUM_SRC*2-1:0]        fwd_origin,
  output logic                        stall,
  output logic [STALL_CNT_W-1:0]      stall_cycles
);

  logic [DATA_W-1:0] ex_res;
  logic [DATA_W-1:0] wb_res;
  logic              ex_live;
  logic              wb_live;
  logic              hazard;
  logic [REG_W-1:0]  sel_w [NUM_SRC];

  logic [HIST-1:0]   hist_valid_q, hist_valid_d;
  logic [REG_W-1:0]  hist_dest_q [HIST];
  logic [REG_W-1:0]  hist_dest_d [HIST];
  logic [DATA_W-1:0] hist_val_q [HIST];
  logic [DATA_W-1:0] hist_val_d [HIST];

  lu_state_t              state_q, state_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

  fwd_result_mux #(.DATA_W(DATA_W)) u_ex_mux (
    .kind(ex_kind), .alu(ex_alu), .imm(ex_imm), .pc(ex_pc),
    .load_data(ex_load_data), .result(ex_res)
  );

  fwd_result_mux #(.DATA_W(DATA_W)) u_wb_mux (
    .kind(wb_kind), .alu(wb_alu), .imm(wb_imm), .pc(wb_pc),
    .load_data(wb_load_data), .result(wb_res)
  );

  assign ex_live = is_live(ex_wen, ex_dest);
  assign wb_live = is_live(wb_wen, wb_dest);

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) sel_w[i] = src_sel[i*REG_W +: REG_W];
  end

  // A matching EX producer blocks older sources even while its load is pending.
  always_comb begin
    fwd_valid  = '0;
    fwd_data   = '0;
    fwd_origin = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!RST && sel_w[i] != '0) begin
        if (ex_live && ex_dest == sel_w[i]) begin
          if (ex_kind != RK_LOAD || mem_ready) begin
            fwd_valid[i]            = 1'b1;
            fwd_data[i*DATA_W +: DATA_W] = ex_res;
            fwd_origin[i*2 +: 2]    = FO_EX;
          end
        end else if (wb_live && wb_dest == sel_w[i]) begin
          fwd_valid[i]            = 1'b1;
          fwd_data[i*DATA_W +: DATA_W] = wb_res;
          fwd_origin[i*2 +: 2]    = FO_WB;
        end else begin
          for (int h = HIST-1; h >= 0; h--) begin
            if (hist_valid_q[h] && hist_dest_q[h] == sel_w[i]) begin
              fwd_valid[i]            = 1'b1;
              fwd_data[i*DATA_W +: DATA_W] = hist_val_q[h];
              fwd_origin[i*2 +: 2]    = FO_HIST;
            end
          end
        end
      end
    end
  end

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_used[i] && sel_w[i] == ex_dest) hazard = 1'b1;
    end
    hazard = hazard && ex_live && (ex_kind == RK_LOAD);
  end

  always_ff @(posedge CLK) begin
    if (RST) state_q <= LU_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = LU_RUN;
    end else begin
      case (state_q)
        LU_RUN:    if (hazard && !mem_ready) state_d = LU_LDWAIT;
        LU_LDWAIT: if (!hazard || mem_ready) state_d = LU_RUN;
        default:   state_d = LU_RUN;
      endcase
    end
  end

  always_comb begin
    stall = 1'b0;
    if (!RST && !flush) begin
      case (state_q)
        LU_RUN:    stall = hazard && !mem_ready;
        LU_LDWAIT: stall = hazard && !mem_ready;
        default:   stall = 1'b0;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  // Entry 0 is the newest retirement; a flush wins over a simultaneous push.
  always_comb begin
    hist_valid_d = hist_valid_q;
    hist_dest_d  = hist_dest_q;
    hist_val_d   = hist_val_q;
    if (flush) begin
      hist_valid_d = '0;
    end else if (adv) begin
      for (int h = HIST-1; h > 0; h--) begin
        hist_valid_d[h] = hist_valid_q[h-1];
        hist_dest_d[h]  = hist_dest_q[h-1];
        hist_val_d[h]   = hist_val_q[h-1];
      end
      hist_valid_d[0] = wb_live;
      hist_dest_d[0]  = wb_dest;
      hist_val_d[0]   = wb_res;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q        <= '0;
      hist_valid_q <= '0;
    end else begin
      cnt_q        <= cnt_d;
      hist_valid_q <= hist_valid_d;
    end
  end

  always_ff @(posedge CLK) begin
    hist_dest_q <= hist_dest_d;
    hist_val_q  <= hist_val_d;
  end

  assign stall_cycles = cnt_q;

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised operand-forwarding and load-use hazard unit for the pipelined datapath. It serves NUM_SRC ID/EX source operands and resolves each one against the EX/MEM producer, the MEM/WB producer and a HIST-deep history of retired writebacks. It also owns the load-use stall state machine. It sits beside the ID/EX register; its outputs drive the operand muxes in front of the ALU and the pipeline stall/enable logic.

## Interface
Parameters:
- NUM_SRC, 2: number of source operands resolved in parallel.
- HIST, 2: depth of the retired-writeback history (≥1).
- DATA_W, 32: data width (LUI result defined only for 32).
- STALL_CNT_W, 16: width of the saturating stall counter.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- src_sel  in  NUM_SRC×5  ID/EX register selects.
- src_used  in  NUM_SRC  source actually read by the instruction.
- ex_wen, ex_dest, ex_kind  in  1/5/2  EX/MEM producer write-enable, destination and result kind.
- ex_alu, ex_imm, ex_pc, ex_load_data  in  DATA_W/16/DATA_W/DATA_W  EX/MEM result sources.
- mem_ready  in  1  data memory returns ex_load_data this cycle.
- wb_wen, wb_dest, wb_kind, wb_alu, wb_imm, wb_pc, wb_load_data  in  as ex_*  MEM/WB producer.
- adv  in  1  pipeline advances this cycle (MEM/WB retires).
- flush  in  1  squash history and the stall FSM.
- fwd_valid  out  NUM_SRC  forward the operand.
- fwd_data  out  NUM_SRC×DATA_W  forwarded value.
- fwd_origin  out  NUM_SRC×2  fwd_origin_t of the winning producer.
- stall  out  1  hold IF/ID and ID/EX, bubble EX/MEM.
- stall_cycles  out  STALL_CNT_W  saturating count of stall cycles.

## Operation
- Result resolution by kind:
  - RK_ALU → alu.
  - RK_LUI → {imm,16'h0}.
  - RK_LINK → pc+4 (mod 2^DATA_W).
  - RK_LOAD → load_data.
- A producer is live when wen=1 and dest≠0.
- Per source i, strict youngest-wins priority:
  1. EX live with dest==src_sel[i] → FO_EX. Load kind forwards only when mem_ready=1.
  2. WB live with matching dest → FO_WB.
  3. History entries, newest to oldest → FO_HIST.
  4. Otherwise FO_NONE, fwd_valid=0, fwd_data=0.
- A matching older producer is never used when a younger one matches, including a matching EX load that is not yet ready.
- Register 0 never forwards.
- History is a shift register of {valid,dest,value}.
  - On adv=1 with WB live, it pushes the resolved WB value; the oldest entry drops.
  - On adv=1 with WB not live, it pushes an invalid entry.
  - On adv=0 it holds.
- Load-use FSM, states RUN and LDWAIT. Hazard = EX live, ex_kind==RK_LOAD, and some i with src_used[i] and src_sel[i]==ex_dest.
  - RUN: hazard and !mem_ready → stall=1, next state LDWAIT. Hazard and mem_ready → no stall, forward ex_load_data.
  - LDWAIT: stall=1 while !mem_ready. When mem_ready=1: stall=0, forward, next state RUN. If the hazard disappears: stall=0, next state RUN.
- flush (ahead of everything except RST): FSM→RUN, all history invalid, stall=0 that cycle.
- stall_cycles increments on each cycle with stall=1 and holds at all-ones.

## Timing
- fwd_valid, fwd_data, fwd_origin and stall are combinational from inputs, history and FSM state, with zero-cycle latency.
- History, FSM state and counter update on the rising edge of CLK.
- Reset values:
  - FSM=RUN, history all invalid, stall_cycles=0.
  - While RST=1: stall=0 and fwd_valid=0.
- An entry pushed at edge t is visible from cycle t+1.
- Simultaneous events:
  - adv=1 together with stall=1 is a caller error; history still follows adv.
  - flush together with a hazard: flush wins.

## Structure
- cpu_types_pkg gains:
  - res_kind_t {RK_ALU,RK_LUI,RK_LINK,RK_LOAD}.
  - fwd_origin_t {FO_NONE,FO_EX,FO_WB,FO_HIST}.
- Sub-module fwd_result_mux resolves kind→value; it is instantiated for EX and WB.

## Test plan
- WB ALU write r5=0x1234, EX idle, src_sel[0]=5 → fwd_valid[0]=1, data 0x1234, FO_WB.
- EX LUI r3 imm 0xABCD and WB ALU r3=7, src_sel[1]=3 → 0xABCD0000, FO_EX (youngest wins).
- EX load r8, src_used[0], src_sel[0]=8, mem_ready low for 3 cycles then high with 0xDEAD → stall for 3 cycles, forward 0xDEAD on the 4th cycle, FSM back in RUN, stall_cycles=3.
- WB writes r9=0x55 with adv=1, then adv=0 for two cycles while EX/WB are idle → src r9 forwarded from history, FO_HIST, value 0x55; after flush → fwd_valid=0.
- Producer with dest=0 and wen=1, src_sel=0 → no forward; EX LINK with pc=0xFFFFFFFC → forwarded value 0x00000000.
- RST asserted while in LDWAIT → next cycle FSM=RUN, stall=0, stall_cycles=0, history empty.
